fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Instruction-fetch controller for the 16-bit core. Owns the program counter: issues fetch requests to instruction memory, holds each fetched word until decode accepts it, then computes the next PC. The next PC is one of sequential (+1), relative branch (sign-extended offset) or absolute jump. It sits between instruction memory and the decode/control stage. It sequences the PC increment, sign-extension and next-PC select datapath.

Parameters:
AW, 10, PC/instruction address width in bits.
OFFW, 8, branch offset width in bits, two's complement.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  begin or resume fetching; sampled in IDLE and HALTED only.
halt_req  input  1  stop after the current instruction; sampled only at accept.
mem_req  output  1  fetch request to instruction memory.
mem_addr  output  AW  fetch address; equals pc while mem_req=1.
mem_ack  input  1  memory returns data this cycle.
mem_rdata  input  16  instruction word; valid only with mem_ack.
instr  output  16  held instruction word.
instr_pc  output  AW  address instr was fetched from.
instr_valid  output  1  instr/instr_pc valid for decode.
instr_ready  input  1  decode accepts instr this cycle.
redir_kind  input  2  next-PC select at accept: 00 sequential, 01 relative, 10 absolute, 11 treated as 00.
redir_offset  input  OFFW  relative branch offset.
redir_target  input  AW  absolute jump target.
pc  output  AW  current PC register.
halted  output  1  high in the HALTED state.

Behaviour:
- States: IDLE, FETCH, HOLD, HALTED.
- Reset (rst=1 at a clock edge, any state, including mid-fetch):
  - State goes to IDLE; pc=RESET_PC.
  - instr=0, instr_pc=0; instr_valid=0, mem_req=0, halted=0.
  - Any outstanding fetch is dropped. mem_ack seen in IDLE or HALTED is ignored.
- IDLE: all outputs are at reset values. start=1 -> FETCH next cycle.
- FETCH:
  - mem_req=1 and mem_addr=pc. Both are held stable until mem_ack.
  - When mem_ack=1: instr<=mem_rdata, instr_pc<=pc, then -> HOLD.
  - mem_ack in the same cycle as the request is legal, giving a minimum 1-cycle fetch.
  - mem_req drops in the cycle after mem_ack.
- HOLD:
  - instr_valid=1; instr and instr_pc are stable until accept.
  - Accept means instr_valid & instr_ready.
  - On accept: pc<=next_pc. Then -> HALTED if halt_req=1, else -> FETCH.
  - Next mem_req is high 1 cycle after accept.
  - Without instr_ready: wait indefinitely; redir_* and halt_req are ignored.
- next_pc, evaluated only at accept with modulo-2^AW wrap in all cases:
  - sequential: instr_pc+1; (2^AW-1)+1 = 0.
  - relative: instr_pc + 1 + sign_extend(redir_offset) to AW bits.
  - absolute: redir_target.
- HALTED: halted=1, mem_req=0, instr_valid=0. pc holds the already-computed next_pc. start=1 -> FETCH at pc.
- halt_req asserted during FETCH does not abort the fetch. It takes effect only at the accept of that instruction.
- Throughput: at most one instruction every 3 cycles (request, ack, accept) with zero-wait memory and decode.
- instr_valid and mem_req are never high in the same cycle.

Test Plan:
- Reset, start, 4 fetches with mem_ack on the request cycle and instr_ready=1 (AW=10, mem_rdata=16'h1000+addr) -> mem_addr sequence 0,1,2,3; instr 1000,1001,1002,1003; accepts 3 cycles apart.
- Accept at instr_pc=0x005 with redir_kind=01, redir_offset=8'hFC -> next mem_addr=0x002. Accept at instr_pc=0x3FE with offset 8'h05 -> next mem_addr=0x004 (wrap).
- Accept with redir_kind=10, redir_target=0x2A0 -> next mem_addr=0x2A0. Accept at instr_pc=0x3FF sequential -> next mem_addr=0x000. redir_kind=11 behaves as sequential.
- Hold instr_ready=0 for 5 cycles, toggling redir_kind and mem_ack -> instr/instr_pc unchanged, mem_req=0. Accept on cycle 6 applies only that cycle's redir values.
- halt_req=1 during FETCH at pc=0x010 -> fetch completes and the instruction is presented; at accept halted=1 and pc=0x011. start=1 -> mem_req with mem_addr=0x011.
- rst=1 in FETCH at pc=0x123 with mem_ack the following cycle -> pc=0x000, mem_req=0, instr_valid=0, state IDLE. The late ack does not set instr_valid.

Source files
------------

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction-fetch controller for the 16-bit core. Owns the program counter.
// It requests a word from instruction memory, holds it for decode until decode
// accepts it, and then picks the next PC. The next PC is sequential, a relative
// branch or an absolute jump.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous reset, active-high
//   start         begin or resume fetching (sampled in IDLE / HALTED)
//   halt_req      stop after the current instruction (sampled at accept)
//   mem_req       fetch request to instruction memory
//   mem_addr      fetch address (equals pc)
//   mem_ack       memory returns mem_rdata this cycle
//   mem_rdata     instruction word from memory
//   instr         held instruction word
//   instr_pc      address that instr was fetched from
//   instr_valid   instr / instr_pc valid for decode
//   instr_ready   decode accepts instr this cycle
//   redir_kind    next-PC select at accept: 00 seq, 01 rel, 10 abs, 11 seq
//   redir_offset  relative branch offset (two's complement)
//   redir_target  absolute jump target
//   pc            current PC register
//   halted        high in HALTED
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int              AW       = 10,
  parameter int              OFFW     = 8,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            halt_req,
  output logic            mem_req,
  output logic [AW-1:0]   mem_addr,
  input  logic            mem_ack,
  input  logic [15:0]     mem_rdata,
  output logic [15:0]     instr,
  output logic [AW-1:0]   instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic [1:0]      redir_kind,
  input  logic [OFFW-1:0] redir_offset,
  input  logic [AW-1:0]   redir_target,
  output logic [AW-1:0]   pc,
  output logic            halted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   instr_q, instr_d;
  logic [AW-1:0] instr_pc_q, instr_pc_d;
  // Set for the first FETCH cycle after an accept. The request goes out one
  // cycle later, which spaces accepts three cycles apart.
  logic          gap_q, gap_d;

  logic          accept;
  logic [AW-1:0] next_pc;
  logic [AW-1:0] seq_pc;

  assign accept = instr_valid & instr_ready;
  assign seq_pc = instr_pc_q + AW'(1);

  // Next-PC select. All sums wrap modulo 2^AW. The offset is sign-extended to
  // AW bits by the signed size cast.
  always_comb begin
    next_pc = seq_pc;
    case (redir_kind)
      2'b01:   next_pc = seq_pc + AW'($signed(redir_offset));
      2'b10:   next_pc = redir_target;
      default: next_pc = seq_pc;   // 00 and the reserved 11
    endcase
  end

  // NOTE: every variable gets a default before the case statement. Without the
  // defaults, a path that does not assign a variable would infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    gap_d      = gap_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          gap_d   = 1'b0;
        end
      end
      FETCH: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (mem_ack) begin
          instr_d    = mem_rdata;
          instr_pc_d = pc_q;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        // redir_* and halt_req only matter in the accept cycle.
        if (accept) begin
          pc_d    = next_pc;
          state_d = halt_req ? HALTED : FETCH;
          gap_d   = ~halt_req;
        end
      end
      HALTED: begin
        if (start) begin
          state_d = FETCH;
          gap_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // update together at the edge, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      gap_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      gap_q      <= gap_d;
    end
  end

  // Outputs decode directly from state, so instr_valid (HOLD) and mem_req
  // (FETCH) can never be high together.
  assign mem_req     = (state_q == FETCH) & ~gap_q;
  assign mem_addr    = pc_q;
  assign instr_valid = (state_q == HOLD);
  assign halted      = (state_q == HALTED);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed bench for fetch_sequencer with AW=10 and OFFW=8. Memory returns
// 16'h1000 + address. Inputs change and outputs are sampled 1 time unit after
// each rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        halt_req;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic [9:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  redir_kind;
  logic [7:0]  redir_offset;
  logic [9:0]  redir_target;
  logic [9:0]  pc;
  logic        halted;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign mem_rdata = 16'h1000 + {6'd0, mem_addr};

  fetch_sequencer #(.AW(10), .OFFW(8), .RESET_PC(10'h000)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .halt_req     (halt_req),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .redir_kind   (redir_kind),
    .redir_offset (redir_offset),
    .redir_target (redir_target),
    .pc           (pc),
    .halted       (halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request cycle: mem_req high at the given address, nothing presented.
  task automatic expect_req(input string tag, input logic [9:0] addr);
    check({tag, ".mem_req"},     32'(mem_req), 32'd1);
    check({tag, ".mem_addr"},    32'(mem_addr), 32'(addr));
    check({tag, ".instr_valid"}, 32'(instr_valid), 32'd0);
  endtask

  // Hold cycle: the word fetched from addr is presented to decode.
  task automatic expect_hold(input string tag, input logic [9:0] addr);
    logic [15:0] word;
    word = 16'h1000 + {6'd0, addr};
    check({tag, ".instr_valid"}, 32'(instr_valid), 32'd1);
    check({tag, ".mem_req"},     32'(mem_req), 32'd0);
    check({tag, ".instr"},       32'(instr), 32'(word));
    check({tag, ".instr_pc"},    32'(instr_pc), 32'(addr));
  endtask

  // Accept with the given redirect. The cycle after the accept is the gap
  // cycle with no request. Returns at the next request cycle.
  task automatic accept(input string tag, input logic [1:0] kind,
                        input logic [7:0] off, input logic [9:0] tgt);
    instr_ready  = 1'b1;
    redir_kind   = kind;
    redir_offset = off;
    redir_target = tgt;
    tick();
    redir_kind   = 2'b00;
    redir_offset = 8'h00;
    redir_target = 10'h000;
    check({tag, ".gap_req"},   32'(mem_req), 32'd0);
    check({tag, ".gap_valid"}, 32'(instr_valid), 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; mem_ack = 1'b0;
    instr_ready = 1'b0; redir_kind = 2'b00; redir_offset = 8'h00; redir_target = 10'h000;

    // Reset state
    tick(); tick();
    check("rst.pc",          32'(pc), 32'h000);
    check("rst.mem_req",     32'(mem_req), 32'd0);
    check("rst.instr_valid", 32'(instr_valid), 32'd0);
    check("rst.halted",      32'(halted), 32'd0);
    check("rst.instr",       32'(instr), 32'h0);
    check("rst.instr_pc",    32'(instr_pc), 32'h0);
    rst = 1'b0;
    tick();
    check("idle.mem_req", 32'(mem_req), 32'd0);

    // Four sequential fetches. The ack arrives in the request cycle, and the
    // accepts fall three cycles apart.
    mem_ack = 1'b1; instr_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_req("seq", 10'(i));
      tick();
      expect_hold("seq", 10'(i));
      accept("seq", 2'b00, 8'h00, 10'h000);
    end
    check("seq.pc", 32'(pc), 32'h004);

    // Absolute jump, relative branches (negative offset and a wrapping one),
    // sequential wrap at 0x3FF, and reserved kind 11 treated as sequential.
    expect_req("abs5", 10'h004);  tick(); expect_hold("abs5", 10'h004);
    accept("abs5", 2'b10, 8'h00, 10'h005);
    expect_req("rel_neg", 10'h005); tick(); expect_hold("rel_neg", 10'h005);
    accept("rel_neg", 2'b01, 8'hFC, 10'h3C0);
    expect_req("abs3fe", 10'h002); tick(); expect_hold("abs3fe", 10'h002);
    accept("abs3fe", 2'b10, 8'h00, 10'h3FE);
    expect_req("rel_wrap", 10'h3FE); tick(); expect_hold("rel_wrap", 10'h3FE);
    accept("rel_wrap", 2'b01, 8'h05, 10'h111);
    expect_req("abs2a0", 10'h004); tick(); expect_hold("abs2a0", 10'h004);
    accept("abs2a0", 2'b10, 8'h33, 10'h2A0);
    expect_req("abs3ff", 10'h2A0); tick(); expect_hold("abs3ff", 10'h2A0);
    accept("abs3ff", 2'b10, 8'h00, 10'h3FF);
    expect_req("seq_wrap", 10'h3FF); tick(); expect_hold("seq_wrap", 10'h3FF);
    accept("seq_wrap", 2'b00, 8'h7F, 10'h155);
    expect_req("kind11", 10'h000); tick(); expect_hold("kind11", 10'h000);
    accept("kind11", 2'b11, 8'h40, 10'h155);

    // Decode stalls for 5 cycles while the redirect inputs and mem_ack toggle.
    expect_req("stall", 10'h001);
    instr_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      redir_kind   = 2'(i + 1);
      redir_offset = 8'h20 + 8'(i);
      redir_target = 10'h155 + 10'(i);
      mem_ack      = i[0];
      halt_req     = i[0];
      expect_hold("stall", 10'h001);
      tick();
    end
    expect_hold("stall6", 10'h001);
    halt_req = 1'b0;
    mem_ack  = 1'b1;
    accept("stall6", 2'b10, 8'h7F, 10'h010);

    // halt_req during a slow fetch: the fetch completes and halt takes effect
    // at the accept.
    halt_req = 1'b1;
    mem_ack  = 1'b0;
    expect_req("halt.f0", 10'h010);
    tick();
    expect_req("halt.f1", 10'h010);
    mem_ack = 1'b1;
    tick();
    expect_hold("halt", 10'h010);
    instr_ready = 1'b1;
    tick();
    halt_req = 1'b0;
    check("halt.halted",      32'(halted), 32'd1);
    check("halt.pc",          32'(pc), 32'h011);
    check("halt.mem_req",     32'(mem_req), 32'd0);
    check("halt.instr_valid", 32'(instr_valid), 32'd0);
    tick();
    check("halt.stay",        32'(halted), 32'd1);
    check("halt.ack_ignored", 32'(instr_valid), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("resume.halted", 32'(halted), 32'd0);
    expect_req("resume", 10'h011);
    tick();
    expect_hold("resume", 10'h011);
    mem_ack = 1'b0;
    accept("to123", 2'b10, 8'h00, 10'h123);

    // Reset in the middle of a fetch at 0x123. The late ack that follows is
    // ignored.
    expect_req("midrst", 10'h123);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_ack = 1'b1;
    check("midrst.pc",          32'(pc), 32'h000);
    check("midrst.mem_req",     32'(mem_req), 32'd0);
    check("midrst.instr_valid", 32'(instr_valid), 32'd0);
    check("midrst.halted",      32'(halted), 32'd0);
    tick();
    check("lateack.instr_valid", 32'(instr_valid), 32'd0);
    check("lateack.mem_req",     32'(mem_req), 32'd0);
    check("lateack.pc",          32'(pc), 32'h000);
    mem_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
